dsp_delay_line: RTL

DSP_DELAY_LINE -- requirements
Module: dsp_delay_line

---
 rtl/dsp_delay_line_if.sv | 25 ++
 rtl/dsp_delay_line.sv | 80 ++++++++
 2 files changed

// File: rtl/dsp_delay_line_if.sv
// rtl/dsp_delay_line_if.sv - handshake/bus bundle for the runtime-selectable delay line
interface dsp_delay_line_if #(
    parameter int WIDTH = 18,
    parameter int SW    = 3
);
    logic             clk_en;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [SW-1:0]    delay_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [SW-1:0]    count;
    logic             busy;

    modport master (
        output clk_en, flush, in_data, in_valid, delay_sel,
        input  out_data, out_valid, count, busy
    );

    modport slave (
        input  clk_en, flush, in_data, in_valid, delay_sel,
        output out_data, out_valid, count, busy
    );
endinterface

// File: rtl/dsp_delay_line.sv
// rtl/dsp_delay_line.sv - valid-qualified shift pipeline with a saturating runtime tap select
module dsp_delay_line #(
    parameter int WIDTH        = 18,
    parameter int MAX_DEPTH    = 4,
    parameter int ZERO_INVALID = 0
) (
    input  logic              clk,
    input  logic              rst,
    dsp_delay_line_if.slave   bus
);
    localparam int SW = $clog2(MAX_DEPTH + 1);

    logic [WIDTH-1:0] w_in_data;
    logic             w_enter;
    logic             w_leave;
    logic [SW-1:0]    w_count_next;
    logic [SW-1:0]    w_tap;

    logic             r_valid [MAX_DEPTH];
    logic [WIDTH-1:0] r_data  [MAX_DEPTH];
    logic [SW-1:0]    r_count;
    logic             r_busy;

    // Zeroing at the entry point is enough: downstream stages only ever copy S[1].
    assign w_in_data = ((ZERO_INVALID != 0) && !bus.in_valid) ? '0 : bus.in_data;
    assign w_enter   = bus.in_valid;
    assign w_leave   = r_valid[MAX_DEPTH-1];

    always_comb begin
        w_count_next = r_count;
        if (w_enter && !w_leave)
            w_count_next = r_count + 1'b1;
        else if (!w_enter && w_leave)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (bus.clk_en) begin
            r_valid[0] <= bus.in_valid;
            r_data[0]  <= w_in_data;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
            r_count <= w_count_next;
            r_busy  <= (w_count_next != '0);
        end
    end

    // Out-of-range selects clamp to the last stage rather than wrapping.
    assign w_tap = (bus.delay_sel > SW'(MAX_DEPTH)) ? SW'(MAX_DEPTH) : bus.delay_sel;

    always_comb begin
        bus.out_valid = bus.in_valid;
        bus.out_data  = w_in_data;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (w_tap == SW'(k)) begin
                bus.out_valid = r_valid[k-1];
                bus.out_data  = r_data[k-1];
            end
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
endmodule
